minirisc_control_fsm: RTL and testbench

//  Multi-cycle control sequencer directly upstream of CPU_TOP_MODULE: fetches, decodes each
//  32-bit KGP miniRISC instruction and drives the datapath control inputs (RegWrite, ALUOp, ...).

---
 rtl/minirisc_control_fsm_pkg.sv | 96 +++++++++
 rtl/minirisc_decode.sv | 75 +++++++
 rtl/minirisc_control_fsm.sv | 180 ++++++++++++++++++
 tb/tb_minirisc_control_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/minirisc_control_fsm_pkg.sv
// Shared definitions for the KGP miniRISC control sequencer: state encoding,
// instruction classes, opcode/funct values and datapath control field codes.
// No ports; imported by minirisc_decode and minirisc_control_fsm.
package minirisc_control_fsm_pkg;

  // Encoding is visible on state_out, so the values are fixed.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Sequencing class of a decoded instruction. K_NONE marks an illegal word.
  typedef enum logic [2:0] {
    K_ALU   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_JUMP  = 3'd3,
    K_HALT  = 3'd4,
    K_NONE  = 3'd5
  } kind_t;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_ANDI  = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_B     = 6'b001000;
  localparam logic [5:0] OP_BR    = 6'b001001;
  localparam logic [5:0] OP_BZ    = 6'b001010;
  localparam logic [5:0] OP_BNZ   = 6'b001011;
  localparam logic [5:0] OP_BLTZ  = 6'b001100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type funct, instr[4:0]
  localparam logic [4:0] FN_ADD   = 5'b00000;
  localparam logic [4:0] FN_AND   = 5'b00001;
  localparam logic [4:0] FN_XOR   = 5'b00010;
  localparam logic [4:0] FN_COMP  = 5'b00011;
  localparam logic [4:0] FN_SHLL  = 5'b00100;
  localparam logic [4:0] FN_SHRL  = 5'b00101;
  localparam logic [4:0] FN_SHRA  = 5'b00110;
  localparam logic [4:0] FN_SHLLV = 5'b00111;
  localparam logic [4:0] FN_SHRLV = 5'b01000;
  localparam logic [4:0] FN_SHRAV = 5'b01001;

  localparam logic [1:0] ALU_NONE = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_XOR  = 2'b11;

  localparam logic [1:0] RD_RS  = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [1:0] SH_LL = 2'b00;
  localparam logic [1:0] SH_RL = 2'b01;
  localparam logic [1:0] SH_RA = 2'b10;

  localparam logic [1:0] BT_NONE = 2'b00;
  localparam logic [1:0] BT_Z    = 2'b01;
  localparam logic [1:0] BT_NZ   = 2'b10;
  localparam logic [1:0] BT_LTZ  = 2'b11;

  localparam logic [1:0] JT_NONE = 2'b00;
  localparam logic [1:0] JT_IMM  = 2'b01;
  localparam logic [1:0] JT_REG  = 2'b10;

  // Static control vector, latched in DECODE and held until the next DECODE.
  typedef struct packed {
    logic       imm_sel;        // 0 = sign-extend imm, 1 = zero-extend
    logic       alu_src;        // 1 = immediate operand
    logic       comp_enbl;
    logic       shift_amnt_sel; // 0 = shamt field, 1 = register
    logic       shift_enbl;
    logic       short_br;
    logic       long_br;
    logic       branch_reg;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] shift_type;
    logic [1:0] branch_type;
    logic [1:0] jump_type;
    logic [1:0] mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/minirisc_decode.sv
// Combinational miniRISC decoder: opcode/funct -> static control vector,
// sequencing class and legal bit.
// Ports: opcode[5:0], funct[4:0] in; ctrl (ctrl_t), kind (kind_t), legal out.
module minirisc_decode
  import minirisc_control_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] funct,
  output ctrl_t      ctrl,
  output kind_t      kind,
  output logic       legal
);

  always_comb begin
    ctrl  = '0;
    kind  = K_NONE;
    legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        kind         = K_ALU;
        ctrl.reg_dst = RD_RS;
        case (funct)
          FN_ADD:   ctrl.alu_op = ALU_ADD;
          FN_AND:   ctrl.alu_op = ALU_AND;
          FN_XOR:   ctrl.alu_op = ALU_XOR;
          FN_COMP:  ctrl.comp_enbl = 1'b1;
          FN_SHLL:  begin ctrl.shift_enbl = 1'b1; ctrl.shift_type = SH_LL; end
          FN_SHRL:  begin ctrl.shift_enbl = 1'b1; ctrl.shift_type = SH_RL; end
          FN_SHRA:  begin ctrl.shift_enbl = 1'b1; ctrl.shift_type = SH_RA; end
          FN_SHLLV: begin
            ctrl.shift_enbl = 1'b1; ctrl.shift_amnt_sel = 1'b1; ctrl.shift_type = SH_LL;
          end
          FN_SHRLV: begin
            ctrl.shift_enbl = 1'b1; ctrl.shift_amnt_sel = 1'b1; ctrl.shift_type = SH_RL;
          end
          FN_SHRAV: begin
            ctrl.shift_enbl = 1'b1; ctrl.shift_amnt_sel = 1'b1; ctrl.shift_type = SH_RA;
          end
          default: begin
            ctrl  = '0;
            kind  = K_NONE;
            legal = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        kind = K_ALU; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.reg_dst = RD_RS;
      end
      OP_ANDI: begin
        kind = K_ALU; ctrl.alu_src = 1'b1; ctrl.imm_sel = 1'b1; ctrl.alu_op = ALU_AND;
      end
      OP_XORI: begin
        kind = K_ALU; ctrl.alu_src = 1'b1; ctrl.imm_sel = 1'b1; ctrl.alu_op = ALU_XOR;
      end
      OP_LW: begin
        kind            = K_LOAD;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.reg_dst    = RD_RT;
        ctrl.mem_to_reg = MTR_MEM;
      end
      OP_SW: begin
        kind = K_STORE; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_B:    begin kind = K_JUMP; ctrl.long_br = 1'b1; ctrl.jump_type = JT_IMM; end
      OP_BR:   begin kind = K_JUMP; ctrl.branch_reg = 1'b1; ctrl.jump_type = JT_REG; end
      OP_BZ:   begin kind = K_JUMP; ctrl.short_br = 1'b1; ctrl.branch_type = BT_Z; end
      OP_BNZ:  begin kind = K_JUMP; ctrl.short_br = 1'b1; ctrl.branch_type = BT_NZ; end
      OP_BLTZ: begin kind = K_JUMP; ctrl.short_br = 1'b1; ctrl.branch_type = BT_LTZ; end
      OP_HALT: kind = K_HALT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/minirisc_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the miniRISC
// datapath, with imem/dmem ready handshakes and a wait-state timeout to HALT.
// Ports:
//   clk, rst (async, active-low); instr[31:0], imem_ready, dmem_ready in
//   imem_req, ir_write, pc_write, RegWrite, MemRead, MemWrite strobes out
//   static datapath controls (ImmSel..MemToReg, BranchReg) out
//   illegal_op pulse, bus_err sticky, halted, state_out[2:0] debug out
module minirisc_control_fsm
  import minirisc_control_fsm_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        RegWrite,
  output logic        ImmSel,
  output logic        ALUSrc,
  output logic        CompEnbl,
  output logic        ShiftAmntSel,
  output logic        ShiftEnbl,
  output logic        ShortBr,
  output logic        LongBr,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        BranchReg,
  output logic [1:0]  ALUOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  ShiftType,
  output logic [1:0]  BranchType,
  output logic [1:0]  JumpType,
  output logic [1:0]  MemToReg,
  output logic        illegal_op,
  output logic        bus_err,
  output logic        halted,
  output logic [2:0]  state_out
);

  localparam logic [3:0] LIMIT = 4'(WAIT_LIMIT);

  state_t     state_q, state_d;
  kind_t      kind_q, dec_kind;
  ctrl_t      ctrl_q, dec_ctrl;
  logic       dec_legal;
  logic [5:0] op_q;
  logic [4:0] funct_q;
  logic [3:0] wait_q, wait_d;
  logic       counting, timeout;
  logic       pc_step;
  logic       unused_instr_bits;

  // Only opcode and funct matter to sequencing; the datapath owns the rest.
  assign unused_instr_bits = ^instr[25:5];

  minirisc_decode u_decode (
    .opcode (op_q),
    .funct  (funct_q),
    .ctrl   (dec_ctrl),
    .kind   (dec_kind),
    .legal  (dec_legal)
  );

  // Handshake strobes follow the ready inputs in the same cycle; everything
  // else is registered. A sw completes (pc_write) in the cycle dmem accepts it.
  assign ir_write = imem_req & imem_ready;
  assign pc_write = pc_step | (MemWrite & dmem_ready);

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req) begin
          if (imem_ready) begin
            state_d = S_DECODE;
          end else if (wait_q == LIMIT) begin
            state_d = S_HALT;
            timeout = 1'b1;
          end
        end
      end
      S_DECODE: state_d = (dec_kind == K_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (kind_q)
          K_ALU:            state_d = S_WB;
          K_LOAD, K_STORE:  state_d = S_MEM;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (kind_q == K_LOAD) ? S_WB : S_FETCH;
        end else if (wait_q == LIMIT) begin
          state_d = S_HALT;
          timeout = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    counting = ((state_q == S_FETCH) && imem_req && !imem_ready) ||
               ((state_q == S_MEM) && !dmem_ready);
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (counting) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Outputs are registered from state_d so they are valid for the whole
  // state and all zero while in reset. The cost is one idle FETCH cycle
  // right after reset release before imem_req rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      kind_q     <= K_NONE;
      ctrl_q     <= '0;
      op_q       <= '0;
      funct_q    <= '0;
      wait_q     <= '0;
      imem_req   <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      RegWrite   <= 1'b0;
      pc_step    <= 1'b0;
      illegal_op <= 1'b0;
      halted     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (ir_write) begin
        op_q    <= instr[31:26];
        funct_q <= instr[4:0];
      end
      if (state_q == S_DECODE) begin
        ctrl_q <= dec_ctrl;
        kind_q <= dec_kind;
      end
      imem_req   <= (state_d == S_FETCH);
      MemRead    <= (state_d == S_MEM) && (kind_q == K_LOAD);
      MemWrite   <= (state_d == S_MEM) && (kind_q == K_STORE);
      RegWrite   <= (state_d == S_WB);
      pc_step    <= (state_d == S_WB) ||
                    ((state_q == S_DECODE) && (state_d == S_EXEC) &&
                     ((dec_kind == K_JUMP) || (dec_kind == K_NONE)));
      illegal_op <= (state_q == S_DECODE) && (state_d == S_EXEC) && !dec_legal;
      halted     <= (state_d == S_HALT);
      bus_err    <= bus_err | timeout;
    end
  end

  assign ImmSel       = ctrl_q.imm_sel;
  assign ALUSrc       = ctrl_q.alu_src;
  assign CompEnbl     = ctrl_q.comp_enbl;
  assign ShiftAmntSel = ctrl_q.shift_amnt_sel;
  assign ShiftEnbl    = ctrl_q.shift_enbl;
  assign ShortBr      = ctrl_q.short_br;
  assign LongBr       = ctrl_q.long_br;
  assign BranchReg    = ctrl_q.branch_reg;
  assign ALUOp        = ctrl_q.alu_op;
  assign RegDst       = ctrl_q.reg_dst;
  assign ShiftType    = ctrl_q.shift_type;
  assign BranchType   = ctrl_q.branch_type;
  assign JumpType     = ctrl_q.jump_type;
  assign MemToReg     = ctrl_q.mem_to_reg;
  assign state_out    = state_q;

endmodule

// File: tb/tb_minirisc_control_fsm.sv
// Directed self-checking bench for minirisc_control_fsm.
module tb_minirisc_control_fsm;

  logic        clk, rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready;
  logic        imem_req, ir_write, pc_write, RegWrite;
  logic        ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr;
  logic        MemRead, MemWrite, BranchReg;
  logic [1:0]  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;
  logic        illegal_op, bus_err, halted;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;

  minirisc_control_fsm #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .RegWrite(RegWrite),
    .ImmSel(ImmSel), .ALUSrc(ALUSrc), .CompEnbl(CompEnbl), .ShiftAmntSel(ShiftAmntSel),
    .ShiftEnbl(ShiftEnbl), .ShortBr(ShortBr), .LongBr(LongBr), .MemRead(MemRead),
    .MemWrite(MemWrite), .BranchReg(BranchReg), .ALUOp(ALUOp), .RegDst(RegDst),
    .ShiftType(ShiftType), .BranchType(BranchType), .JumpType(JumpType),
    .MemToReg(MemToReg), .illegal_op(illegal_op), .bus_err(bus_err), .halted(halted),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bundle: {imem_req, ir_write, pc_write, RegWrite, MemRead, MemWrite,
  //                 illegal_op, bus_err, halted}
  logic [8:0] stb;
  assign stb = {imem_req, ir_write, pc_write, RegWrite, MemRead, MemWrite,
                illegal_op, bus_err, halted};

  // Control bundle: {ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr,
  //                  LongBr, BranchReg, ALUOp, RegDst, ShiftType, BranchType,
  //                  JumpType, MemToReg}
  logic [19:0] ctrl;
  assign ctrl = {ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr,
                 BranchReg, ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg};

  localparam logic [8:0] NONE = 9'b0_0000_0000;
  localparam logic [8:0] IREQ = 9'b1_0000_0000;
  localparam logic [8:0] IRW  = 9'b0_1000_0000;
  localparam logic [8:0] PCW  = 9'b0_0100_0000;
  localparam logic [8:0] RW   = 9'b0_0010_0000;
  localparam logic [8:0] MR   = 9'b0_0001_0000;
  localparam logic [8:0] MW   = 9'b0_0000_1000;
  localparam logic [8:0] ILL  = 9'b0_0000_0100;
  localparam logic [8:0] BERR = 9'b0_0000_0010;
  localparam logic [8:0] HLT  = 9'b0_0000_0001;

  localparam logic [31:0] W_ADDI  = 32'h0400_0000;  // op 000001
  localparam logic [31:0] W_LW    = 32'h1000_0000;  // op 000100
  localparam logic [31:0] W_SW    = 32'h1400_0000;  // op 000101
  localparam logic [31:0] W_B     = 32'h2000_0000;  // op 001000
  localparam logic [31:0] W_XOR   = 32'h0123_4562;  // op 000000 funct 00010
  localparam logic [31:0] W_SHRAV = 32'h0000_0009;  // op 000000 funct 01001
  localparam logic [31:0] W_BADOP = 32'hA800_0000;  // op 101010
  localparam logic [31:0] W_BADFN = 32'h0000_001F;  // op 000000 funct 11111
  localparam logic [31:0] W_HALT  = 32'hFC00_0000;  // op 111111

  localparam logic [19:0] C_ADDI  = {8'b0100_0000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] C_LW    = {8'b0100_0000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
  localparam logic [19:0] C_SW    = {8'b0100_0000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] C_B     = {8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
  localparam logic [19:0] C_XOR   = {8'b0000_0000, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] C_SHRAV = {8'b0001_1000, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [19:0] C_ZERO  = 20'h0_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [8:0] s, input logic [2:0] st);
    check({tag, ".strobes"}, 32'(stb), 32'(s));
    check({tag, ".state"}, 32'(state_out), 32'(st));
  endtask

  task automatic expect_ctrl(input string tag, input logic [19:0] c);
    check({tag, ".ctrl"}, 32'(ctrl), 32'(c));
  endtask

  // Advance to the next negedge, apply inputs for that cycle, settle.
  task automatic cyc(input logic ir, input logic dr, input logic [31:0] w);
    @(negedge clk);
    imem_ready = ir;
    dmem_ready = dr;
    instr      = w;
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; instr = '0;
    @(negedge clk); #1;
    expect_cyc("reset", NONE, 3'd0);
    expect_ctrl("reset", C_ZERO);
    @(negedge clk); rst = 1'b1;
    cyc(0, 0, '0); expect_cyc("release", IREQ, 3'd0);

    // addi: ir_write c0, RegWrite+pc_write c3
    cyc(1, 0, W_ADDI); expect_cyc("addi.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("addi.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("addi.c2", NONE, 3'd2); expect_ctrl("addi", C_ADDI);
    cyc(0, 0, '0);     expect_cyc("addi.c3", RW | PCW, 3'd4);
    cyc(0, 0, '0);     expect_cyc("addi.fetch", IREQ, 3'd0);

    // lw with two dmem wait cycles
    cyc(1, 0, W_LW);   expect_cyc("lw.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("lw.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("lw.c2", NONE, 3'd2); expect_ctrl("lw.exec", C_LW);
    cyc(0, 0, '0);     expect_cyc("lw.mem0", MR, 3'd3);
    cyc(0, 0, '0);     expect_cyc("lw.mem1", MR, 3'd3);
    cyc(0, 1, '0);     expect_cyc("lw.mem2", MR, 3'd3);
    cyc(0, 0, '0);     expect_cyc("lw.wb", RW | PCW, 3'd4); expect_ctrl("lw.wb", C_LW);
    cyc(0, 0, '0);     expect_cyc("lw.fetch", IREQ, 3'd0);

    // sw with immediate dmem_ready
    cyc(1, 0, W_SW);   expect_cyc("sw.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("sw.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("sw.c2", NONE, 3'd2); expect_ctrl("sw", C_SW);
    cyc(0, 1, '0);     expect_cyc("sw.mem", MW | PCW, 3'd3);
    cyc(0, 0, '0);     expect_cyc("sw.fetch", IREQ, 3'd0);

    // branch: 3 cycles
    cyc(1, 0, W_B);    expect_cyc("b.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("b.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("b.c2", PCW, 3'd2); expect_ctrl("b", C_B);
    cyc(0, 0, '0);     expect_cyc("b.fetch", IREQ, 3'd0);

    // R-type xor and shrav
    cyc(1, 0, W_XOR);  expect_cyc("xor.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("xor.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("xor.c2", NONE, 3'd2); expect_ctrl("xor", C_XOR);
    cyc(0, 0, '0);     expect_cyc("xor.c3", RW | PCW, 3'd4);
    cyc(1, 0, W_SHRAV); expect_cyc("shrav.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("shrav.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("shrav.c2", NONE, 3'd2); expect_ctrl("shrav", C_SHRAV);
    cyc(0, 0, '0);     expect_cyc("shrav.c3", RW | PCW, 3'd4);

    // illegal opcode and illegal funct
    cyc(1, 0, W_BADOP); expect_cyc("badop.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("badop.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("badop.c2", ILL | PCW, 3'd2); expect_ctrl("badop", C_ZERO);
    cyc(0, 0, '0);     expect_cyc("badop.fetch", IREQ, 3'd0);
    cyc(1, 0, W_BADFN); expect_cyc("badfn.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("badfn.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("badfn.c2", ILL | PCW, 3'd2);
    cyc(0, 0, '0);     expect_cyc("badfn.fetch", IREQ, 3'd0);

    // reset asserted mid-MEM of sw
    cyc(1, 0, W_SW);   expect_cyc("swrst.c0", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("swrst.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("swrst.c2", NONE, 3'd2);
    cyc(0, 0, '0);     expect_cyc("swrst.mem", MW, 3'd3);
    #2; rst = 1'b0; #1;
    expect_cyc("swrst.async", NONE, 3'd0);
    cyc(0, 1, '0);     expect_cyc("swrst.held", NONE, 3'd0);
    @(negedge clk); rst = 1'b1;
    cyc(0, 0, '0);     expect_cyc("swrst.release", IREQ, 3'd0);

    // halt opcode
    cyc(1, 0, W_HALT); expect_cyc("halt.c0", IREQ | IRW, 3'd0);
    cyc(1, 0, '0);     expect_cyc("halt.c1", NONE, 3'd1);
    cyc(1, 1, '0);     expect_cyc("halt.c2", HLT, 3'd5);
    cyc(1, 1, '0);     expect_cyc("halt.c3", HLT, 3'd5);
    @(negedge clk); rst = 1'b0; #1;
    expect_cyc("halt.reset", NONE, 3'd0);
    @(negedge clk); rst = 1'b1;

    // fetch: 15 wait cycles, ready arrives in the limit cycle and wins
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, '0);   expect_cyc("fwait", IREQ, 3'd0);
    end
    cyc(1, 0, W_LW);   expect_cyc("fwait.limit", IREQ | IRW, 3'd0);
    cyc(0, 0, '0);     expect_cyc("to.c1", NONE, 3'd1);
    cyc(0, 0, '0);     expect_cyc("to.c2", NONE, 3'd2);

    // dmem_ready stuck low: 16 MEM cycles then bus_err + HALT
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, '0);   expect_cyc("to.mem", MR, 3'd3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, '0);   expect_cyc("to.halt", BERR | HLT, 3'd5);
    end
    @(negedge clk); rst = 1'b0; #1;
    expect_cyc("to.reset", NONE, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
